// File: rtl/instr_dec_mc.sv
// instr_dec_mc: opcode decoder for the stack FP core with stall FSM for channel input and fixed-latency divide.
// Illegal opcodes decode to a NOP and pulse illegal for one cycle.
module instr_dec_mc #(
    parameter int NBDATA = 32,
    parameter int NBOPCO = 6,
    parameter int NBOPER = 9,
    parameter int MDATAW = 8,
    parameter int NUMIOS = 4,
    parameter int DIVCYC = 4,
    localparam int NBIOAD = (NUMIOS > 1) ? $clog2(NUMIOS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NBOPCO-1:0] opcode,
    input  logic [NBOPER-1:0] operand,
    output logic              stall,
    output logic              dsp_push,
    output logic              dsp_pop,
    output logic              mem_wr,
    output logic [MDATAW-1:0] mem_addr,
    input  logic [NBDATA-1:0] mem_data_in,
    output logic [3:0]        ula_op,
    output logic              acc_wr,
    output logic [NBDATA-1:0] ula_data,
    input  logic [NBDATA-1:0] io_in,
    input  logic              in_ack,
    output logic              req_in,
    output logic [NBIOAD-1:0] io_addr,
    output logic              out_en,
    output logic              srf,
    output logic              neg,
    output logic              illegal
);
    typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_DIV} state_t;

    state_t            state_q, state_d;
    logic [3:0]        ula_op_q, ula_op_d;
    logic              acc_wr_q, acc_wr_d, req_in_q, req_in_d, out_en_q, out_en_d;
    logic              srf_q, srf_d, neg_q, neg_d, illegal_q, illegal_d, sel_io_q, sel_io_d;
    logic [NBIOAD-1:0] io_addr_q, io_addr_d;
    logic [NBDATA-1:0] io_lat_q, io_lat_d;
    logic [7:0]        cnt_q, cnt_d;

    logic       legal, push_f, pop_f, wr_f, srf_f, neg_f, out_f, is_in, is_div, idle;
    logic [3:0] ula_f;

    always_comb begin
        legal = 1'b1;
        ula_f = 4'd0;
        push_f = 1'b0;
        pop_f = 1'b0;
        wr_f = 1'b0;
        srf_f = 1'b0;
        neg_f = 1'b0;
        out_f = 1'b0;
        case (int'(opcode))
            0: ula_f = 4'd1;
            1: begin ula_f = 4'd1; push_f = 1'b1; wr_f = 1'b1; end
            2: wr_f = 1'b1;
            3: begin ula_f = 4'd1; wr_f = 1'b1; pop_f = 1'b1; end
            4: begin push_f = 1'b1; wr_f = 1'b1; end
            5, 6, 7, 8: ;
            9: begin pop_f = 1'b1; srf_f = 1'b1; end
            10: begin ula_f = 4'd1; pop_f = 1'b1; end
            11: begin pop_f = 1'b1; out_f = 1'b1; end
            12: ula_f = 4'd5;
            14: ula_f = 4'd2;
            15: begin ula_f = 4'd2; pop_f = 1'b1; end
            16: ula_f = 4'd3;
            17: begin ula_f = 4'd3; pop_f = 1'b1; end
            18: ula_f = 4'd4;
            19: begin ula_f = 4'd4; pop_f = 1'b1; end
            24: ula_f = 4'd9;
            25: begin ula_f = 4'd9; pop_f = 1'b1; end
            28: ula_f = 4'd11;
            29: begin ula_f = 4'd11; pop_f = 1'b1; end
            36: ula_f = 4'd8;
            38: ula_f = 4'd7;
            39: begin ula_f = 4'd7; pop_f = 1'b1; end
            40: ula_f = 4'd10;
            41: begin ula_f = 4'd10; pop_f = 1'b1; end
            42: ula_f = 4'd6;
            43: begin ula_f = 4'd6; pop_f = 1'b1; end
            44: begin wr_f = 1'b1; neg_f = 1'b1; end
            45: begin ula_f = 4'd1; wr_f = 1'b1; pop_f = 1'b1; neg_f = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    assign is_in  = int'(opcode) == 10;
    assign is_div = int'(opcode) == 18 || int'(opcode) == 19;
    assign idle   = state_q == IDLE;

    // Stack/memory strobes only in IDLE so a held opcode fires them once.
    assign dsp_push = idle && push_f;
    assign dsp_pop  = idle && pop_f;
    assign mem_wr   = idle && wr_f;
    assign mem_addr = operand[MDATAW-1:0];
    assign stall    = !idle || is_in || (is_div && DIVCYC != 0);
    assign ula_data = sel_io_q ? io_lat_q : mem_data_in;

    always_comb begin
        state_d = state_q;
        ula_op_d = ula_op_q;
        acc_wr_d = 1'b0;
        req_in_d = req_in_q;
        io_addr_d = io_addr_q;
        out_en_d = 1'b0;
        srf_d = 1'b0;
        neg_d = 1'b0;
        illegal_d = 1'b0;
        sel_io_d = sel_io_q;
        io_lat_d = io_lat_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                sel_io_d = 1'b0;
                req_in_d = 1'b0;
                if (!legal) begin
                    illegal_d = 1'b1;
                    ula_op_d = 4'd0;
                end else if (is_in) begin
                    ula_op_d = 4'd1;
                    req_in_d = 1'b1;
                    io_addr_d = operand[NBIOAD-1:0];
                    sel_io_d = 1'b1;
                    state_d = WAIT_IN;
                end else if (is_div) begin
                    ula_op_d = 4'd4;
                    if (DIVCYC == 0) begin
                        acc_wr_d = 1'b1;
                    end else begin
                        cnt_d = 8'(DIVCYC - 1);
                        state_d = WAIT_DIV;
                    end
                end else begin
                    ula_op_d = ula_f;
                    acc_wr_d = ula_f != 4'd0;
                    out_en_d = out_f;
                    srf_d = srf_f;
                    neg_d = neg_f;
                end
            end
            WAIT_IN: if (in_ack) begin
                io_lat_d = io_in;
                req_in_d = 1'b0;
                acc_wr_d = 1'b1;
                state_d = IDLE;
            end
            WAIT_DIV: if (cnt_q == 8'd0) begin
                acc_wr_d = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ula_op_q <= 4'd0;
            acc_wr_q <= 1'b0;
            req_in_q <= 1'b0;
            io_addr_q <= '0;
            out_en_q <= 1'b0;
            srf_q <= 1'b0;
            neg_q <= 1'b0;
            illegal_q <= 1'b0;
            sel_io_q <= 1'b0;
            io_lat_q <= '0;
            cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ula_op_q <= ula_op_d;
            acc_wr_q <= acc_wr_d;
            req_in_q <= req_in_d;
            io_addr_q <= io_addr_d;
            out_en_q <= out_en_d;
            srf_q <= srf_d;
            neg_q <= neg_d;
            illegal_q <= illegal_d;
            sel_io_q <= sel_io_d;
            io_lat_q <= io_lat_d;
            cnt_q <= cnt_d;
        end
    end

    assign ula_op  = ula_op_q;
    assign acc_wr  = acc_wr_q;
    assign req_in  = req_in_q;
    assign io_addr = io_addr_q;
    assign out_en  = out_en_q;
    assign srf     = srf_q;
    assign neg     = neg_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_instr_dec_mc.sv
// tb_instr_dec_mc: drives two decoders (DIVCYC=4 and DIVCYC=0) with shared stimulus and checks
// them every cycle against an opcode-table model, plus hand-computed directed expectations.
module tb_instr_dec_mc;
    typedef struct packed {
        logic       legal;
        logic [3:0] ula;
        logic       push, pop, wr, srf, neg, oute, stl;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b0, in_ack = 1'b0, chk_on = 1'b0;
    logic [5:0]  opcode = 6'd5;
    logic [8:0]  operand = '0;
    logic [31:0] mem_data_in = '0, io_in = '0;

    logic        stall[2], dsp_push[2], dsp_pop[2], mem_wr[2], acc_wr[2], req_in[2];
    logic        out_en[2], srf[2], neg[2], illegal[2];
    logic [7:0]  mem_addr[2];
    logic [3:0]  ula_op[2];
    logic [31:0] ula_data[2];
    logic [1:0]  io_addr[2];

    int compared = 0, mismatched = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        instr_dec_mc #(.DIVCYC(g == 0 ? 4 : 0)) u_dut (
            .clk(clk), .rst(rst), .opcode(opcode), .operand(operand),
            .stall(stall[g]), .dsp_push(dsp_push[g]), .dsp_pop(dsp_pop[g]), .mem_wr(mem_wr[g]),
            .mem_addr(mem_addr[g]), .mem_data_in(mem_data_in), .ula_op(ula_op[g]), .acc_wr(acc_wr[g]),
            .ula_data(ula_data[g]), .io_in(io_in), .in_ack(in_ack), .req_in(req_in[g]),
            .io_addr(io_addr[g]), .out_en(out_en[g]), .srf(srf[g]), .neg(neg[g]), .illegal(illegal[g])
        );
    end

    always #5 clk = ~clk;

    ent_t tab[64];
    int   dcv[2] = '{4, 0};

    task automatic sp(input int op, input int u, input logic pu, po, wr, sr, ng, oe, st);
        tab[op] = {1'b1, 4'(u), pu, po, wr, sr, ng, oe, st};
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, d, $time, a, e);
        end
    endtask

    // Model: bk = 0 free, 1 waiting for input ack, 2 dividing with dl cycles left.
    int          bk[2], dl[2];
    logic [3:0]  e_ula[2];
    logic        e_acc[2], e_req[2], e_out[2], e_srf[2], e_neg[2], e_ill[2], e_sel[2];
    logic [1:0]  e_ioad[2];
    logic [31:0] e_lat[2];
    ent_t        mt;

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                bk[d] = 0; dl[d] = 0; e_ula[d] = 0; e_acc[d] = 0; e_req[d] = 0; e_out[d] = 0;
                e_srf[d] = 0; e_neg[d] = 0; e_ill[d] = 0; e_sel[d] = 0; e_ioad[d] = 0; e_lat[d] = 0;
            end else begin
                mt = tab[opcode];
                e_acc[d] = 0; e_out[d] = 0; e_srf[d] = 0; e_neg[d] = 0; e_ill[d] = 0;
                if (bk[d] == 0) begin
                    e_sel[d] = 0; e_req[d] = 0;
                    if (!mt.legal) begin
                        e_ill[d] = 1; e_ula[d] = 0;
                    end else if (opcode == 10) begin
                        e_ula[d] = 1; e_req[d] = 1; e_ioad[d] = 2'(operand % 4); e_sel[d] = 1; bk[d] = 1;
                    end else if (opcode == 18 || opcode == 19) begin
                        e_ula[d] = 4;
                        if (dcv[d] == 0) e_acc[d] = 1;
                        else begin bk[d] = 2; dl[d] = dcv[d]; end
                    end else begin
                        e_ula[d] = mt.ula; e_acc[d] = mt.ula != 0;
                        e_out[d] = mt.oute; e_srf[d] = mt.srf; e_neg[d] = mt.neg;
                    end
                end else if (bk[d] == 1) begin
                    if (in_ack) begin e_lat[d] = io_in; e_req[d] = 0; e_acc[d] = 1; bk[d] = 0; end
                end else begin
                    dl[d]--;
                    if (dl[d] == 0) begin e_acc[d] = 1; bk[d] = 0; end
                end
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        for (int d = 0; d < 2; d++) begin
            ent_t t;
            logic busy, isdiv;
            t = tab[opcode];
            busy = bk[d] != 0;
            isdiv = opcode == 18 || opcode == 19;
            chk("stall", d, 32'(stall[d]), 32'(busy || (t.stl && !(dcv[d] == 0 && isdiv))));
            chk("dsp_push", d, 32'(dsp_push[d]), 32'(!busy && t.push));
            chk("dsp_pop", d, 32'(dsp_pop[d]), 32'(!busy && t.pop));
            chk("mem_wr", d, 32'(mem_wr[d]), 32'(!busy && t.wr));
            chk("mem_addr", d, 32'(mem_addr[d]), 32'(operand[7:0]));
            chk("ula_op", d, 32'(ula_op[d]), 32'(e_ula[d]));
            chk("acc_wr", d, 32'(acc_wr[d]), 32'(e_acc[d]));
            chk("ula_data", d, ula_data[d], e_sel[d] ? e_lat[d] : mem_data_in);
            chk("req_in", d, 32'(req_in[d]), 32'(e_req[d]));
            chk("io_addr", d, 32'(io_addr[d]), 32'(e_ioad[d]));
            chk("out_en", d, 32'(out_en[d]), 32'(e_out[d]));
            chk("srf", d, 32'(srf[d]), 32'(e_srf[d]));
            chk("neg", d, 32'(neg[d]), 32'(e_neg[d]));
            chk("illegal", d, 32'(illegal[d]), 32'(e_ill[d]));
        end
    end

    task automatic drive(input logic [5:0] op, input logic [8:0] opr, input logic ack,
                         input logic [31:0] din, input logic [31:0] md);
        opcode = op; operand = opr; in_ack = ack; io_in = din; mem_data_in = md;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops, stl0, stl1, reqs, accs;
        sp(0, 1, 0, 0, 0, 0, 0, 0, 0);  sp(1, 1, 1, 0, 1, 0, 0, 0, 0);
        sp(2, 0, 0, 0, 1, 0, 0, 0, 0);  sp(3, 1, 0, 1, 1, 0, 0, 0, 0);
        sp(4, 0, 1, 0, 1, 0, 0, 0, 0);
        for (int o = 5; o <= 8; o++) sp(o, 0, 0, 0, 0, 0, 0, 0, 0);
        sp(9, 0, 0, 1, 0, 1, 0, 0, 0);  sp(10, 1, 0, 1, 0, 0, 0, 0, 1);
        sp(11, 0, 0, 1, 0, 0, 0, 1, 0); sp(12, 5, 0, 0, 0, 0, 0, 0, 0);
        sp(14, 2, 0, 0, 0, 0, 0, 0, 0); sp(15, 2, 0, 1, 0, 0, 0, 0, 0);
        sp(16, 3, 0, 0, 0, 0, 0, 0, 0); sp(17, 3, 0, 1, 0, 0, 0, 0, 0);
        sp(18, 4, 0, 0, 0, 0, 0, 0, 1); sp(19, 4, 0, 1, 0, 0, 0, 0, 1);
        sp(24, 9, 0, 0, 0, 0, 0, 0, 0); sp(25, 9, 0, 1, 0, 0, 0, 0, 0);
        sp(28, 11, 0, 0, 0, 0, 0, 0, 0); sp(29, 11, 0, 1, 0, 0, 0, 0, 0);
        sp(36, 8, 0, 0, 0, 0, 0, 0, 0);
        sp(38, 7, 0, 0, 0, 0, 0, 0, 0); sp(39, 7, 0, 1, 0, 0, 0, 0, 0);
        sp(40, 10, 0, 0, 0, 0, 0, 0, 0); sp(41, 10, 0, 1, 0, 0, 0, 0, 0);
        sp(42, 6, 0, 0, 0, 0, 0, 0, 0); sp(43, 6, 0, 1, 0, 0, 0, 0, 0);
        sp(44, 0, 0, 0, 1, 0, 1, 0, 0); sp(45, 1, 0, 1, 1, 0, 1, 0, 0);

        #1 rst = 1'b1;
        #1;
        chk("rst_ula_op", 0, 32'(ula_op[0]), 0);
        chk("rst_acc_wr", 0, 32'(acc_wr[0]), 0);
        chk("rst_req_in", 0, 32'(req_in[0]), 0);
        chk("rst_illegal", 0, 32'(illegal[0]), 0);
        chk("rst_stall", 0, 32'(stall[0]), 0);
        chk_on = 1'b1;
        tick();
        rst = 1'b0;

        drive(6'd0, 9'h005, 0, 0, 32'h3F800000);
        chk("load_addr", 0, 32'(mem_addr[0]), 32'h05);
        chk("load_stall", 0, 32'(stall[0]), 0);
        tick();
        drive(6'd6, 0, 0, 0, 32'h3F800000);
        chk("load_ula_op", 0, 32'(ula_op[0]), 1);
        chk("load_acc_wr", 0, 32'(acc_wr[0]), 1);
        chk("load_data", 0, ula_data[0], 32'h3F800000);
        tick();

        pops = 0; stl0 = 0; reqs = 0;
        for (int i = 0; i < 5; i++) begin
            drive(6'd10, 9'd2, i == 4, i == 4 ? 32'h40490FDB : 32'h0, 32'h1111);
            pops += int'(dsp_pop[0]); stl0 += int'(stall[0]); reqs += int'(req_in[0]);
            if (i == 1) chk("in_io_addr", 0, 32'(io_addr[0]), 2);
            tick();
        end
        drive(6'd6, 0, 0, 0, 32'h1111);
        chk("in_acc_wr", 0, 32'(acc_wr[0]), 1);
        chk("in_data", 0, ula_data[0], 32'h40490FDB);
        chk("in_stall_after", 0, 32'(stall[0]), 0);
        chk("in_pops", 0, pops, 1);
        chk("in_stall_cyc", 0, stl0, 5);
        chk("in_req_cyc", 0, reqs, 4);
        tick();

        pops = 0; stl0 = 0; stl1 = 0; accs = 0;
        for (int i = 0; i < 5; i++) begin
            drive(6'd19, 9'd7, 0, 0, 32'h2222);
            pops += int'(dsp_pop[0]); stl0 += int'(stall[0]); stl1 += int'(stall[1]);
            if (i > 0) begin
                accs += int'(acc_wr[0]);
                chk("div_ula_op", 0, 32'(ula_op[0]), 4);
            end
            tick();
        end
        drive(6'd6, 0, 0, 0, 32'h2222);
        accs += int'(acc_wr[0]);
        chk("div_acc_end", 0, 32'(acc_wr[0]), 1);
        chk("div_pops", 0, pops, 1);
        chk("div_stall_cyc", 0, stl0, 5);
        chk("div_acc_pulses", 0, accs, 1);
        chk("div0_stall_cyc", 1, stl1, 0);
        tick();

        drive(6'd13, 9'h1FF, 0, 0, 0);
        chk("ill13_stall", 0, 32'(stall[0]), 0);
        chk("ill13_ctl", 0, 32'({dsp_push[0], dsp_pop[0], mem_wr[0]}), 0);
        tick();
        drive(6'd63, 0, 0, 0, 0);
        chk("ill13_pulse", 0, 32'(illegal[0]), 1);
        chk("ill13_acc", 0, 32'(acc_wr[0]), 0);
        tick();
        drive(6'd6, 0, 0, 0, 0);
        chk("ill63_pulse", 0, 32'(illegal[0]), 1);
        tick();
        drive(6'd6, 0, 0, 0, 0);
        chk("ill_clear", 0, 32'(illegal[0]), 0);
        tick();

        drive(6'd45, 9'h10, 0, 0, 32'h3333);
        chk("psetp_wr", 0, 32'(mem_wr[0]), 1);
        chk("psetp_pop", 0, 32'(dsp_pop[0]), 1);
        tick();
        drive(6'd6, 0, 0, 0, 32'h3333);
        chk("psetp_ula", 0, 32'(ula_op[0]), 1);
        chk("psetp_neg", 0, 32'(neg[0]), 1);
        chk("psetp_acc", 0, 32'(acc_wr[0]), 1);
        tick();

        drive(6'd10, 9'd1, 0, 0, 32'h4444);
        tick();
        drive(6'd10, 9'd1, 0, 0, 32'h4444);
        tick();
        rst = 1'b1;
        drive(6'd0, 9'd3, 1, 32'hDEAD, 32'h4444);
        chk("rst_in_req", 0, 32'(req_in[0]), 0);
        chk("rst_in_stall", 0, 32'(stall[0]), 0);
        tick();
        rst = 1'b0;
        drive(6'd0, 9'd3, 0, 0, 32'h5555);
        chk("rst_in_noacc", 0, 32'(acc_wr[0]), 0);
        tick();
        drive(6'd6, 0, 0, 0, 32'h5555);
        chk("rst_load_acc", 0, 32'(acc_wr[0]), 1);
        chk("rst_load_data", 0, ula_data[0], 32'h5555);
        tick();

        for (int o = 0; o < 64; o++) begin
            if (o == 10 || o == 18 || o == 19) continue;
            drive(6'(o), 9'(o * 37), 1'($urandom), $urandom, $urandom);
            tick();
        end
        drive(6'd6, 0, 0, 0, 0);
        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instr_dec_mc.md
# instr_dec_mc

Multi-cycle instruction decoder for the stack-based floating-point processor core. It sits between the fetch stage and the ULA/stack/data-memory datapath and translates the 6-bit opcode into datapath controls. It adds a stall FSM for two kinds of instruction: handshaked I/O input on one of several channels, and a fixed-latency divider. Unknown opcodes execute as safe NOPs and raise a flag.

## Interface
- NBDATA, 32, data width
- NBOPCO, 6, opcode width
- NBOPER, 9, operand width
- MDATAW, 8, data-memory address width (≤ NBOPER)
- NUMIOS, 4, input channel count (≥1); NBIOAD = max(1, clog2(NUMIOS)) ≤ NBOPER
- DIVCYC, 4, extra divider cycles (0..255)

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- opcode  in  NBOPCO  current instruction; core holds it stable while stall=1
- operand  in  NBOPER  current operand
- stall  out  1  hold PC/instruction (combinational)
- dsp_push, dsp_pop  out  1  stack controls (combinational)
- mem_wr  out  1  data-memory write (combinational)
- mem_addr  out  MDATAW  operand[MDATAW-1:0]
- mem_data_in  in  NBDATA  memory read data
- ula_op  out  4  ULA operation (registered)
- acc_wr  out  1  accumulator load enable (registered)
- ula_data  out  NBDATA  sel_io ? io_lat : mem_data_in
- io_in  in  NBDATA  input data
- in_ack  in  1  input channel has data on io_in
- req_in  out  1  input request, held until ack (registered)
- io_addr  out  NBIOAD  channel select (registered)
- out_en  out  1  output strobe (registered)
- srf, neg  out  1  register-file set / clamp-negative (registered)
- illegal  out  1  one-cycle pulse: undefined opcode (registered)

## Operation
- Decode, as opcode: ula_op; flags. A pop or push flag drives the matching stack signal; a wr flag drives mem_wr.
  - 0 LOAD: 1.
  - 1 PLD: 1; push, wr.
  - 2 SET: 0; wr.
  - 3 SETP: 1; wr, pop.
  - 4 PUSH: 0; push, wr.
  - 5–8 JZ/JMP/CALL/RET: 0.
  - 9 SRF: 0; pop, srf.
  - 10 IN: 1; pop, stalling.
  - 11 OUT: 0; pop, out_en.
  - 12 NEG: 5.
  - 14/15 ADD/SADD: 2.
  - 16/17 MLT/SMLT: 3.
  - 18/19 DIV/SDIV: 4, stalling.
  - 24/25: 9.
  - 28/29: 11.
  - 36: 8.
  - 38/39: 7.
  - 40/41: 10.
  - 42/43: 6.
  - 44 PSET: 0; wr, neg.
  - 45 PSETP: 1; wr, pop, neg.
  - In each pair the odd "S" form also pops. All other opcodes are illegal.
- acc_wr is loaded with (decoded ula_op != 0) on non-stalling instructions. For stalling instructions it is 0 at issue and pulses at completion.
- Illegal opcode: everything 0; illegal=1 for one cycle; no stall.
- FSM states: IDLE, WAIT_IN, WAIT_DIV.
  - IDLE, opcode IN:
    - Issue cycle: stall=1, pop pulses.
    - At the clock edge: req_in←1, io_addr←operand[NBIOAD-1:0] (values ≥ NUMIOS wrap modulo 2^NBIOAD and are not checked), ula_op←1, sel_io←1 → WAIT_IN.
  - WAIT_IN:
    - stall=1; stack and memory controls are 0.
    - On the edge with in_ack=1: io_lat←io_in, req_in←0, acc_wr←1 → IDLE.
    - sel_io clears one cycle after acc_wr.
  - IDLE, opcode 18/19:
    - Issue cycle: stall=1; pop pulses for SDIV.
    - If DIVCYC=0: acc_wr←1 at the edge and stay in IDLE.
    - Otherwise: cnt←DIVCYC-1 → WAIT_DIV.
  - WAIT_DIV:
    - stall=1; cnt decrements each cycle.
    - On the edge with cnt==0: acc_wr←1 → IDLE.
- Combinational stack and memory controls are active only in IDLE, so each pulses exactly once per instruction.
- stall = state≠IDLE OR (IDLE AND opcode∈{10,18,19} AND NOT (DIVCYC=0 AND opcode∈{18,19})).

## Timing
- Reset: every registered output is 0, state=IDLE, cnt=0, io_lat=0, sel_io=0. With rst=1, the combinational outputs still decode opcode; the core must not advance during reset.
- Reset in WAIT_IN or WAIT_DIV aborts the instruction: no acc_wr, req_in drops immediately.
- Non-stalling instruction: registered outputs are valid 1 cycle after issue; combinational outputs are valid in the issue cycle.
- IN: stall is high for 1 + (cycles until ack) cycles. acc_wr is high the cycle after the ack edge, with ula_data=io_lat; stall is 0 in that cycle.
- An ack already high in the first WAIT_IN cycle completes there (minimum 2 stall cycles). in_ack is ignored outside WAIT_IN.
- DIV: stall is high for exactly 1+DIVCYC cycles; acc_wr follows on the next cycle. DIVCYC=0 behaves as a single cycle.

## Test plan
- LOAD 0x05 with mem_data_in=0x3F800000 → mem_addr=0x05, no stall; next cycle ula_op=1, acc_wr=1, ula_data=0x3F800000.
- IN, operand=2, in_ack raised on the 4th WAIT_IN cycle with io_in=0x40490FDB:
  - dsp_pop pulses once.
  - io_addr=2; req_in high 4 cycles; stall high 5 cycles.
  - acc_wr=1 with ula_data=0x40490FDB.
- SDIV with DIVCYC=4 → pop once, stall high 5 cycles, ula_op=4 throughout, single acc_wr pulse. Repeat with DIVCYC=0 → no stall.
- Opcode 13 and opcode 63 → all controls 0, illegal pulses 1 cycle each, no stall.
- rst asserted on the 2nd WAIT_IN cycle → req_in=0 and stall=0 immediately; after release, LOAD decodes normally.
- PSETP → mem_wr=1 and dsp_pop=1 in the issue cycle; next cycle ula_op=1, neg=1, acc_wr=1.
